// File: rtl/flit_arbiter.sv
// Round-robin flit arbiter with packet locking and a registered output.
// Define FLIT_ARB_TIMEOUT_EN to release a stalled lock after TIMEOUT cycles.
module flit_arbiter #(
    parameter int W_DIR   = 5,
    parameter int W_FLIT  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [W_DIR*W_FLIT-1:0]   IN,
    output logic [W_DIR-1:0]          IN_ACK,
    output logic [W_FLIT-1:0]         OUT,
    input  logic                      OUT_READY,
    output logic                      ERR
);

    localparam int PW = (W_DIR > 8) ? $clog2(W_DIR) : 3;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     own_q, own_d;
    logic [W_FLIT-1:0] out_d;
    logic [W_FLIT-1:0] flit [W_DIR];
    logic [W_DIR-1:0]  vld;
    logic [W_DIR-1:0]  tail;
    logic              free;
    logic              found;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     cand;
    logic [PW-1:0]     sel;
    logic              acc;
    logic              timeout_hit;
    int                rr_idx;

    for (genvar g = 0; g < W_DIR; g++) begin : g_split
        assign flit[g] = IN[g*W_FLIT +: W_FLIT];
        assign vld[g]  = flit[g][W_FLIT-1];
        assign tail[g] = flit[g][W_FLIT-2];
    end

    assign free = !OUT[W_FLIT-1] || OUT_READY;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (int'(p) >= W_DIR - 1) ? '0 : p + 1'b1;
    endfunction

    // First valid port at or above PTR, wrapping around.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        cand   = '0;
        rr_idx = 0;
        for (int k = 0; k < W_DIR; k++) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= W_DIR) rr_idx = rr_idx - W_DIR;
            cand = PW'(rr_idx);
            if (!found && vld[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        sel     = own_q;
        acc     = 1'b0;
        case (state_q)
            IDLE: begin
                sel = pick;
                if (free && found) begin
                    acc = 1'b1;
                    if (tail[pick]) begin
                        ptr_d = next_port(pick);
                    end else begin
                        own_d   = pick;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (free && vld[own_q]) begin
                    acc = 1'b1;
                    if (tail[own_q]) begin
                        state_d = IDLE;
                        ptr_d   = next_port(own_q);
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    ptr_d   = next_port(own_q);
                end
            end
            default: state_d = IDLE;
        endcase
        if (RST) acc = 1'b0;
        IN_ACK      = '0;
        IN_ACK[sel] = acc;
        out_d = OUT;
        if (free) out_d = acc ? flit[sel] : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            OUT     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            OUT     <= out_d;
        end
    end

`ifdef FLIT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          stall;
    logic          err_q;

    // Owner has a free slot but nothing to send.
    assign stall       = (state_q == LOCKED) && free && !vld[own_q];
    assign timeout_hit = stall && (cnt_q == CW'(TIMEOUT - 1));
    assign ERR         = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q != LOCKED || acc || timeout_hit) cnt_q <= '0;
            else if (stall) cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;

    assign timeout_hit = 1'b0;
    assign ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_flit_arbiter.sv
// Scoreboard bench for flit_arbiter: per-port flit streams, expected
// output flits queued at drive time and compared one cycle later.
module tb_flit_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        OUT_READY;
    logic [39:0] IN;
    logic [4:0]  IN_ACK;
    logic [7:0]  OUT;
    logic        ERR;

    always #5 CLK = ~CLK;

    flit_arbiter #(.W_DIR(5), .W_FLIT(8), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .IN(IN), .IN_ACK(IN_ACK),
        .OUT(OUT), .OUT_READY(OUT_READY), .ERR(ERR)
    );

    logic [7:0] src [5][16];
    int         hd [5];
    int         n [5];
    logic [7:0] exp_q [$];
    logic [7:0] exp_f;
    logic [4:0] ack_s;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic logic [7:0] head(input int p);
        return (hd[p] < n[p]) ? src[p][hd[p]] : 8'h00;
    endfunction

    function automatic int port_of(input logic [4:0] a);
        int r = 0;
        for (int i = 0; i < 5; i++) if (a[i]) r = i;
        return r;
    endfunction

    task automatic load(input int p, input logic [7:0] f);
        src[p][n[p]] = f;
        n[p] = n[p] + 1;
    endtask

    task automatic clear_src();
        for (int p = 0; p < 5; p++) begin
            hd[p] = 0;
            n[p]  = 0;
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 5; p++) IN[p*8 +: 8] = head(p);
    endtask

    task automatic tick();
        drive();
        @(negedge CLK);
        ack_s = IN_ACK;
        @(posedge CLK);
        #1;
        for (int p = 0; p < 5; p++)
            if (ack_s[p] && hd[p] < n[p]) hd[p] = hd[p] + 1;
        drive();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        OUT_READY = 1'b1;
        clear_src();
        exp_q.delete();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        OUT_READY = 1'b1;
        clear_src();
        for (int p = 0; p < 5; p++) load(p, 8'hC0 + 8'(p));
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (ack_s !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_ack c=%0d got %b want 00000", c, ack_s);
            end
            vectors++;
            if (OUT !== 8'h00 || ERR !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out c=%0d got %h/%b want 00/0", c, OUT, ERR);
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_single_flits();
        logic [4:0] tbl [3] = '{5'b00001, 5'b00100, 5'b00000};
        do_reset();
        load(0, 8'hC1);
        load(2, 8'hC2);
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(tbl[c] == 0 ? 8'h00 : head(port_of(tbl[c])));
            tick();
            vectors++;
            if (ack_s !== tbl[c]) begin
                miscompares++;
                $display("FAIL single_ack c=%0d got %b want %b", c, ack_s, tbl[c]);
            end
            exp_f = exp_q.pop_front();
            vectors++;
            if (OUT !== exp_f) begin
                miscompares++;
                $display("FAIL single_out c=%0d got %h want %h", c, OUT, exp_f);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [4:0] tbl [8] = '{5'b00001, 5'b00010, 5'b00010, 5'b00010,
                                5'b00001, 5'b00010, 5'b00001, 5'b00000};
        do_reset();
        load(0, 8'hC0); load(0, 8'hC5); load(0, 8'hC6);
        load(1, 8'h81); load(1, 8'h82); load(1, 8'hC3); load(1, 8'hC7);
        for (int c = 0; c < 8; c++) begin
            exp_q.push_back(tbl[c] == 0 ? 8'h00 : head(port_of(tbl[c])));
            tick();
            vectors++;
            if (ack_s !== tbl[c]) begin
                miscompares++;
                $display("FAIL lock_ack c=%0d got %b want %b", c, ack_s, tbl[c]);
            end
            exp_f = exp_q.pop_front();
            vectors++;
            if (OUT !== exp_f) begin
                miscompares++;
                $display("FAIL lock_out c=%0d got %h want %h", c, OUT, exp_f);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] tbl [10];
        do_reset();
        for (int c = 0; c < 10; c++) tbl[c] = 5'b00001 << (c % 5);
        for (int p = 0; p < 5; p++)
            for (int k = 0; k < 3; k++) load(p, 8'hC0 + 8'(p*8 + k));
        for (int c = 0; c < 10; c++) begin
            exp_q.push_back(head(port_of(tbl[c])));
            tick();
            vectors++;
            if (ack_s !== tbl[c]) begin
                miscompares++;
                $display("FAIL rr_ack c=%0d got %b want %b", c, ack_s, tbl[c]);
            end
            exp_f = exp_q.pop_front();
            vectors++;
            if (OUT !== exp_f) begin
                miscompares++;
                $display("FAIL rr_out c=%0d got %h want %h", c, OUT, exp_f);
            end
        end
    endtask

    task automatic test_stall();
        logic       rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0] tbl [5] = '{5'b00001, 5'b0, 5'b0, 5'b0, 5'b00010};
        logic [7:0] last = 8'h00;
        do_reset();
        load(0, 8'hC1);
        load(1, 8'hC2);
        for (int c = 0; c < 5; c++) begin
            OUT_READY = rdy[c];
            if (tbl[c] != 0) exp_q.push_back(head(port_of(tbl[c])));
            else exp_q.push_back(last[7] && !rdy[c] ? last : 8'h00);
            tick();
            vectors++;
            if (ack_s !== tbl[c]) begin
                miscompares++;
                $display("FAIL stall_ack c=%0d got %b want %b", c, ack_s, tbl[c]);
            end
            exp_f = exp_q.pop_front();
            last = exp_f;
            vectors++;
            if (OUT !== exp_f) begin
                miscompares++;
                $display("FAIL stall_out c=%0d got %h want %h", c, OUT, exp_f);
            end
        end
        OUT_READY = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [4:0] tbl [3] = '{5'b01000, 5'b00000, 5'b00001};
        do_reset();
        load(3, 8'h81); load(3, 8'h82); load(3, 8'hC3);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                load(0, 8'hC5);
                RST = 1'b1;
            end
            if (c == 2) begin
                RST = 1'b0;
                hd[3] = n[3];
            end
            exp_q.push_back(tbl[c] == 0 ? 8'h00 : head(port_of(tbl[c])));
            tick();
            vectors++;
            if (ack_s !== tbl[c]) begin
                miscompares++;
                $display("FAIL rstmid_ack c=%0d got %b want %b", c, ack_s, tbl[c]);
            end
            exp_f = exp_q.pop_front();
            vectors++;
            if (OUT !== exp_f) begin
                miscompares++;
                $display("FAIL rstmid_out c=%0d got %h want %h", c, OUT, exp_f);
            end
        end
    endtask

    task automatic test_timeout();
        logic [4:0] e_ack;
        logic       e_err;
        int         ncyc;
`ifdef FLIT_ARB_TIMEOUT_EN
        ncyc = 18;
`else
        ncyc = 21;
`endif
        do_reset();
        load(2, 8'h81);
        load(4, 8'hC4);
        for (int c = 0; c < ncyc; c++) begin
            e_ack = 5'b0;
            e_err = 1'b0;
            if (c == 0) e_ack = 5'b00100;
`ifdef FLIT_ARB_TIMEOUT_EN
            if (c == 17) e_ack = 5'b10000;
            e_err = (c >= 16);
`endif
            exp_q.push_back(e_ack == 0 ? 8'h00 : head(port_of(e_ack)));
            tick();
            vectors++;
            if (ack_s !== e_ack) begin
                miscompares++;
                $display("FAIL tmo_ack c=%0d got %b want %b", c, ack_s, e_ack);
            end
            exp_f = exp_q.pop_front();
            vectors++;
            if (OUT !== exp_f || ERR !== e_err) begin
                miscompares++;
                $display("FAIL tmo_out c=%0d got %h/%b want %h/%b",
                         c, OUT, ERR, exp_f, e_err);
            end
        end
        do_reset();
        vectors++;
        if (ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_err_clear got %b want 0", ERR);
        end
    endtask

    initial begin
        RST = 1'b1;
        OUT_READY = 1'b1;
        IN = '0;
        clear_src();
        test_reset();
        test_single_flits();
        test_packet_lock();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/flit_arbiter.md
FLIT_ARBITER -- requirements
Module: flit_arbiter

Interface
REQ-001 Parameter W_DIR, default 5: number of input ports.
REQ-002 Parameter W_FLIT, default 8: flit width; bit W_FLIT-1 = valid, bit W_FLIT-2 = tail, remaining bits = payload.
REQ-003 Parameter TIMEOUT, default 16: stall limit in cycles for a locked owner (used only when FLIT_ARB_TIMEOUT_EN is defined).
REQ-004 CLK  input  1  the single clock; all state updates on its posedge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 IN  input  W_DIR*W_FLIT  input flits; port i occupies bits [i*W_FLIT +: W_FLIT].
REQ-007 IN_ACK  output  W_DIR  one-hot or zero; bit i high = flit on port i is accepted this cycle.
REQ-008 OUT  output  W_FLIT  registered output flit; MSB = valid.
REQ-009 OUT_READY  input  1  downstream accepts OUT this cycle when OUT valid.
REQ-010 ERR  output  1  sticky timeout error flag.

Function
REQ-011 Port i SHALL request whenever its valid bit is 1; a requester SHALL hold its flit stable until IN_ACK[i].
REQ-012 The output register is "free" when OUT valid is 0 or OUT_READY is 1; acceptance SHALL occur only when free.
REQ-013 IN_ACK SHALL be combinational, at most one bit set, and zero when the output register is not free.
REQ-014 A flit accepted in cycle N SHALL appear on OUT in cycle N+1; sustained throughput SHALL be one flit per cycle.
REQ-015 When free and nothing is accepted, OUT valid SHALL clear to 0 next cycle; when not free, OUT SHALL hold.
REQ-016 FSM states: IDLE and LOCKED; a 3-bit-or-wider round-robin pointer PTR and an owner index OWN.
REQ-017 IDLE: grant the first valid port searching from PTR upward, wrapping W_DIR-1 to 0.
REQ-018 IDLE grant of a non-tail flit SHALL set OWN to the granted port and enter LOCKED.
REQ-019 IDLE grant of a tail flit (single-flit packet) SHALL remain IDLE and set PTR to granted+1 mod W_DIR.
REQ-020 LOCKED: only port OWN SHALL be accepted; other valid ports SHALL receive no IN_ACK.
REQ-021 LOCKED: acceptance of a tail flit from OWN SHALL return to IDLE and set PTR to OWN+1 mod W_DIR.
REQ-022 PTR SHALL change only on tail acceptance (or timeout release); no requester waits more than W_DIR packets.

Reset
REQ-023 On RST high at a posedge: OUT=0, state IDLE, PTR=0, OWN=0, ERR=0, stall counter 0.
REQ-024 IN_ACK SHALL be 0 in every cycle RST is high.
REQ-025 Reset mid-packet SHALL drop the lock and discard the OUT flit; no partial-packet recovery.

Configuration
REQ-026 Macro FLIT_ARB_TIMEOUT_EN defined: in LOCKED, a counter SHALL increment each cycle the output is free and OWN is not valid, and clear on any acceptance from OWN.
REQ-027 With FLIT_ARB_TIMEOUT_EN, counter reaching TIMEOUT SHALL force IDLE, set PTR to OWN+1 mod W_DIR, and set ERR=1 until reset.
REQ-028 Without FLIT_ARB_TIMEOUT_EN: no counter, LOCKED persists indefinitely, ERR tied to 0.

Verification
REQ-029 Reset, then IN ports 0 and 2 hold tail flits 8'hC1/8'hC2, OUT_READY=1 -> IN_ACK=00001 then 00100; OUT=C1 then C2 one cycle after each ack.
REQ-030 Port 1 sends 8'h81,8'h82,8'hC3 while port 0 holds 8'hC5 -> port 1 acked three consecutive cycles, port 0 acked only in fourth, PTR=2 after packet.
REQ-031 OUT valid with OUT_READY=0 for 3 cycles -> OUT unchanged, IN_ACK=0 throughout, acceptance resumes in the cycle OUT_READY returns 1.
REQ-032 All five ports hold tail flits continuously, PTR=4 -> grant order 4,0,1,2,3, one per cycle.
REQ-033 RST asserted after first flit 8'h81 of a port-3 packet -> next cycle OUT=0, IDLE, PTR=0; port-0 tail flit granted next.
REQ-034 With FLIT_ARB_TIMEOUT_EN, TIMEOUT=16: port 2 sends 8'h81 then goes invalid, port 4 valid -> ERR=1 and port 4 granted after 16 stall cycles; without macro port 4 never granted.
